// File: rtl/gate_vector_checker.sv
// Response checker for the basicgates block: captures, compares and scores gate vectors per run.
// Optional macro GATE_CHK_COVER_EN adds {A,B} coverage tracking and makes pass require full coverage.
module gate_vector_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic             A,
  input  logic             B,
  input  logic             AND,
  input  logic             OR,
  input  logic             NOTA,
  input  logic             NAND,
  input  logic             NOR,
  input  logic             ExOR,
  input  logic             ExNOR,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic [6:0]       fail_mask,
  output logic [3:0]       cov_mask
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] L_NUM = CNT_W'(NUM_VEC);

  // Bit order matches fail_mask: AND, OR, NOTA, NAND, NOR, ExOR, ExNOR.
  function automatic logic [6:0] exp_gates(input logic a, input logic b);
    return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic             r_s1_vld;
  logic             r_s1_a;
  logic             r_s1_b;
  logic [6:0]       r_s1_out;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [1:0]       r_fail_vec;
  logic [6:0]       r_fail_mask;

  logic             w_start_ok;
  logic             w_acc_ok;
  logic             w_cmp;
  logic             w_last;
  logic [6:0]       w_mask;
  logic             w_cov_ok;

  assign w_start_ok = start && (r_state != S_RUN);
  assign w_acc_ok   = (r_state == S_RUN) && vld && (r_acc_cnt < L_NUM);
  assign w_cmp      = (r_state == S_RUN) && r_s1_vld;
  assign w_last     = w_cmp && (r_vec_cnt == (L_NUM - {{(CNT_W-1){1'b0}}, 1'b1}));
  assign w_mask     = r_s1_out ^ exp_gates(r_s1_a, r_s1_b);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = start ? S_RUN : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture stage, compare stage and run scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_a      <= 1'b0;
      r_s1_b      <= 1'b0;
      r_s1_out    <= 7'd0;
      r_acc_cnt   <= '0;
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_fail_vec  <= 2'd0;
      r_fail_mask <= 7'd0;
    end else if (w_start_ok) begin
      r_s1_vld    <= 1'b0;
      r_acc_cnt   <= '0;
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_fail_vec  <= 2'd0;
      r_fail_mask <= 7'd0;
    end else begin
      r_s1_vld <= w_acc_ok;
      if (w_acc_ok) begin
        r_s1_a    <= A;
        r_s1_b    <= B;
        r_s1_out  <= {AND, OR, NOTA, NAND, NOR, ExOR, ExNOR};
        r_acc_cnt <= r_acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_cmp) begin
        r_vec_cnt <= r_vec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (w_mask != 7'd0) begin
          if (r_err_cnt != {CNT_W{1'b1}}) begin
            r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          // err_cnt never returns to zero within a run, so zero marks the first failure
          if (r_err_cnt == '0) begin
            r_fail_vec  <= {r_s1_a, r_s1_b};
            r_fail_mask <= w_mask;
          end
        end
      end
    end
  end

`ifdef GATE_CHK_COVER_EN
  logic [3:0] r_cov;

  // Coverage of {A,B} combinations seen by the compare stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cov <= 4'd0;
    end else if (w_start_ok) begin
      r_cov <= 4'd0;
    end else if (w_cmp) begin
      r_cov[{r_s1_a, r_s1_b}] <= 1'b1;
    end
  end

  assign cov_mask = r_cov;
  assign w_cov_ok = (r_cov == 4'b1111);
`else
  assign cov_mask = 4'd0;
  assign w_cov_ok = 1'b1;
`endif

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_err_cnt == '0) && w_cov_ok;
  assign vec_cnt   = r_vec_cnt;
  assign err_cnt   = r_err_cnt;
  assign fail_vec  = r_fail_vec;
  assign fail_mask = r_fail_mask;

endmodule
